ls669_sweep_ctrl: RTL and testbench

Synchronous sequencer that drives a cascade of `sn74ls669` 4-bit up/down counters. It sits directly upstream of the chain. It presets a start value through the counters' parallel load, then enables counting in the requested direction and watches the top stage's ripple-carry. At terminal count it either finishes (single sweep) or reverses direction (ping-pong). It generates every counter control pin, so it is the only block that ever writes the counter chain.

---
 rtl/ls669_sweep_ctrl.sv | 101 ++++++++++
 tb/tb_ls669_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ls669_sweep_ctrl.sv
// Sweep sequencer for a cascade of sn74ls669 up/down counters: presets the chain,
// counts in the requested direction, and finishes or reverses at terminal count.
module ls669_sweep_ctrl #(
  parameter int WIDTH = 12,
  parameter int LAPW  = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic             DIR_UP,
  input  logic [WIDTH-1:0] START_VAL,
  input  logic             STEP_EN,
  input  logic             RCO_IN,
  output logic             LOADn,
  output logic             U_Dn,
  output logic             ENABLE_Pn,
  output logic             ENABLE_Tn,
  output logic [WIDTH-1:0] DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [LAPW-1:0]  LAPS
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] COUNT  = 3'd2;
  localparam logic [2:0] TURN   = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  logic [2:0] state;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      LOADn     <= 1'b1;
      U_Dn      <= 1'b1;
      ENABLE_Tn <= 1'b1;
      DATA      <= '0;
      BUSY      <= 1'b0;
      LAPS      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            DATA  <= START_VAL;
            U_Dn  <= DIR_UP;
            LOADn <= 1'b0;
            BUSY  <= 1'b1;
            LAPS  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          // the chain completes its load on this edge even when aborting
          LOADn <= 1'b1;
          if (STOP) begin
            state <= FINISH;
          end else begin
            ENABLE_Tn <= 1'b0;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (STOP) begin
            ENABLE_Tn <= 1'b1;
            state     <= FINISH;
          end else if (!RCO_IN) begin
            if (MODE) begin
              U_Dn  <= ~U_Dn;
              LAPS  <= LAPS + 1'b1;
              state <= TURN;
            end else begin
              ENABLE_Tn <= 1'b1;
              state     <= FINISH;
            end
          end
        end
        TURN: begin
          if (STOP) begin
            ENABLE_Tn <= 1'b1;
            state     <= FINISH;
          end else begin
            state <= COUNT;
          end
        end
        FINISH: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Parallel enable held high at terminal count so the chain never wraps.
  assign ENABLE_Pn = (state == COUNT) ? ~(STEP_EN & RCO_IN) : 1'b1;
  assign DONE      = (state == FINISH);

endmodule

// File: tb/tb_ls669_sweep_ctrl.sv
// Bench for ls669_sweep_ctrl: behavioural counter chain, directed sweeps,
// DONE-event scoreboard plus inline per-cycle checks.
module tb_ls669_sweep_ctrl;

  logic        CLOCK, RESET, START, STOP, MODE, DIR_UP, STEP_EN, RCO_IN;
  logic [11:0] START_VAL, DATA;
  logic        LOADn, U_Dn, ENABLE_Pn, ENABLE_Tn, BUSY, DONE;
  logic [7:0]  LAPS;

  ls669_sweep_ctrl #(.WIDTH(12), .LAPW(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .STOP(STOP), .MODE(MODE),
    .DIR_UP(DIR_UP), .START_VAL(START_VAL), .STEP_EN(STEP_EN), .RCO_IN(RCO_IN),
    .LOADn(LOADn), .U_Dn(U_Dn), .ENABLE_Pn(ENABLE_Pn), .ENABLE_Tn(ENABLE_Tn),
    .DATA(DATA), .BUSY(BUSY), .DONE(DONE), .LAPS(LAPS)
  );

  initial CLOCK = 1'b0;
  always #50 CLOCK = ~CLOCK;

  // Whole-chain equivalent of three cascaded sn74ls669 stages (no reset).
  logic [11:0] q = '0;
  always @(posedge CLOCK) begin
    if (!LOADn) q <= DATA;
    else if (!ENABLE_Pn && !ENABLE_Tn) q <= U_Dn ? q + 12'd1 : q - 12'd1;
  end
  assign RCO_IN = ~(!ENABLE_Tn && (U_Dn ? (&q) : ~(|q)));

  typedef struct {
    logic [11:0] q;
    logic [7:0]  laps;
    logic        u_dn;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic start_sweep(input logic [11:0] v, input logic d, input logic m);
    START_VAL = v;
    DIR_UP    = d;
    MODE      = m;
    START     = 1'b1;
    tick;
    START     = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    int i = 0;
    while (BUSY && i < n) begin
      tick;
      i++;
    end
    chk("wait_idle_timeout", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic push(input logic [11:0] eq, input logic [7:0] el, input logic ed);
    exp_t e;
    e.q = eq; e.laps = el; e.u_dn = ed;
    sb.push_back(e);
  endtask

  // Monitor: every DONE cycle must match the next queued sweep result.
  always begin
    @(posedge CLOCK);
    #1;
    if (DONE) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_unexpected: got DONE=1 q=%0h expected no DONE", q);
      end else begin
        mon_e = sb.pop_front();
        chk("done_q",    {20'd0, q},    {20'd0, mon_e.q});
        chk("done_laps", {24'd0, LAPS}, {24'd0, mon_e.laps});
        chk("done_u_dn", {31'd0, U_Dn}, {31'd0, mon_e.u_dn});
        chk("done_busy", {31'd0, BUSY}, 32'd1);
        chk("done_ent",  {31'd0, ENABLE_Tn}, 32'd1);
      end
    end
  end

  initial begin
    int i;
    RESET = 1'b1; START = 1'b1; STOP = 1'b0; MODE = 1'b0; DIR_UP = 1'b1;
    START_VAL = 12'hABC; STEP_EN = 1'b1;

    // reset with START held
    tick; tick;
    chk("rst_ctrl", {26'd0, LOADn, U_Dn, ENABLE_Tn, ENABLE_Pn, BUSY, DONE}, 32'b111100);
    chk("rst_data", {20'd0, DATA}, 32'd0);
    chk("rst_laps", {24'd0, LAPS}, 32'd0);
    START = 1'b0;
    tick;
    RESET = 1'b0;
    tick;
    chk("idle_after_rst", {31'd0, BUSY}, 32'd0);

    // single up sweep 0xFF0 -> 0xFFF
    push(12'hFFF, 8'd0, 1'b1);
    start_sweep(12'hFF0, 1'b1, 1'b0);
    chk("t1_load", {30'd0, LOADn, BUSY}, 32'b01);
    chk("t1_data", {20'd0, DATA}, 32'hFF0);
    tick;
    chk("t1_q_loaded", {20'd0, q}, 32'hFF0);
    chk("t1_ent", {31'd0, ENABLE_Tn}, 32'd0);
    repeat (15) tick;
    chk("t1_q_term", {20'd0, q}, 32'hFFF);
    chk("t1_rco", {31'd0, RCO_IN}, 32'd0);
    wait_idle(10);
    repeat (3) tick;
    chk("t1_no_wrap", {20'd0, q}, 32'hFFF);
    chk("t1_enp", {31'd0, ENABLE_Pn}, 32'd1);

    // ping-pong from 0x002 down
    push(12'hFFF, 8'd2, 1'b0);
    start_sweep(12'h002, 1'b0, 1'b1);
    tick; chk("pp_q2", {20'd0, q}, 32'h2); chk("pp_dn", {31'd0, U_Dn}, 32'd0);
    tick; chk("pp_q1", {20'd0, q}, 32'h1);
    tick; chk("pp_q0", {20'd0, q}, 32'h0);
    tick; chk("pp_turn_q", {20'd0, q}, 32'h0);
    chk("pp_turn_up", {31'd0, U_Dn}, 32'd1);
    chk("pp_laps1", {24'd0, LAPS}, 32'd1);
    tick; chk("pp_settle_q", {20'd0, q}, 32'h0);
    tick; chk("pp_up_q1", {20'd0, q}, 32'h1);
    tick; chk("pp_up_q2", {20'd0, q}, 32'h2);
    i = 0;
    while (LAPS != 8'd2 && i < 5000) begin
      tick;
      i++;
    end
    chk("pp_laps2", {24'd0, LAPS}, 32'd2);
    chk("pp_dn2", {31'd0, U_Dn}, 32'd0);
    chk("pp_top_q", {20'd0, q}, 32'hFFF);
    STOP = 1'b1;
    tick;
    STOP = 1'b0;
    wait_idle(5);

    // rate gating, STEP_EN = 1,0,0,1
    push(12'h102, 8'd0, 1'b1);
    start_sweep(12'h100, 1'b1, 1'b0);
    tick; chk("rg_q0", {20'd0, q}, 32'h100);
    tick; chk("rg_q1", {20'd0, q}, 32'h101);
    STEP_EN = 1'b0;
    tick; chk("rg_hold1", {20'd0, q}, 32'h101);
    tick; chk("rg_hold2", {20'd0, q}, 32'h101);
    STEP_EN = 1'b1;
    tick; chk("rg_q2", {20'd0, q}, 32'h102);
    STEP_EN = 1'b0; STOP = 1'b1;
    tick;
    STOP = 1'b0; STEP_EN = 1'b1;
    wait_idle(5);

    // STOP coincident with terminal count in ping-pong
    push(12'hFFF, 8'd0, 1'b1);
    start_sweep(12'hFFD, 1'b1, 1'b1);
    tick; tick; tick;
    chk("pri_q", {20'd0, q}, 32'hFFF);
    chk("pri_rco", {31'd0, RCO_IN}, 32'd0);
    STOP = 1'b1;
    tick;
    STOP = 1'b0;
    chk("pri_done", {31'd0, DONE}, 32'd1);
    chk("pri_laps", {24'd0, LAPS}, 32'd0);
    chk("pri_udn", {31'd0, U_Dn}, 32'd1);
    wait_idle(5);

    // START during COUNT must not reload
    push(12'h012, 8'd0, 1'b1);
    start_sweep(12'h010, 1'b1, 1'b0);
    tick; tick;
    chk("sc_q", {20'd0, q}, 32'h011);
    START = 1'b1; START_VAL = 12'h800;
    tick;
    START = 1'b0;
    chk("sc_no_reload", {20'd0, q}, 32'h012);
    chk("sc_data", {20'd0, DATA}, 32'h010);
    chk("sc_loadn", {31'd0, LOADn}, 32'd1);
    STEP_EN = 1'b0; STOP = 1'b1;
    tick;
    STOP = 1'b0; STEP_EN = 1'b1;
    wait_idle(5);

    // STOP during LOAD still loads the chain
    push(12'h555, 8'd0, 1'b0);
    start_sweep(12'h555, 1'b0, 1'b0);
    STOP = 1'b1;
    tick;
    STOP = 1'b0;
    chk("sl_q", {20'd0, q}, 32'h555);
    chk("sl_done", {31'd0, DONE}, 32'd1);
    wait_idle(5);

    // RESET mid-COUNT freezes the chain at 0x345
    start_sweep(12'h340, 1'b1, 1'b0);
    tick;
    repeat (4) tick;
    chk("rm_q344", {20'd0, q}, 32'h344);
    RESET = 1'b1;
    tick;
    chk("rm_q345", {20'd0, q}, 32'h345);
    chk("rm_ctrl", {27'd0, ENABLE_Pn, ENABLE_Tn, LOADn, BUSY, DONE}, 32'b11100);
    chk("rm_regs", {11'd0, U_Dn, LAPS, DATA}, {11'd0, 1'b1, 8'd0, 12'd0});
    RESET = 1'b0;
    repeat (10) tick;
    chk("rm_frozen", {20'd0, q}, 32'h345);

    tick;
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
